gray_counter: RTL and testbench

Parametrised up/down counter that holds a binary count and publishes a registered Gray-coded copy of it. Both values update on the same clock edge. The block supports synchronous load of either a binary or a Gray-coded value and emits a wrap pulse at the count boundaries. It replaces the stand-alone combinational binary-to-Gray converter wherever a Gray sequence is generated locally, such as pointer generation and position encoders.

---
 rtl/gray_counter.sv | 64 ++++++
 tb/tb_gray_counter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray-coded copy, binary/Gray load and wrap pulse.
// Latency: one clk from sampled load/en to outputs; no backpressure, en gates every step.
module gray_counter #(
  parameter int unsigned           WIDTH     = 4,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic             load_gray,
  input  logic [WIDTH-1:0] ld_val,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);
  localparam logic [WIDTH-1:0] RESET_GRAY = RESET_VAL ^ (RESET_VAL >> 1);

  logic [WIDTH-1:0] ld_bin;
  logic [WIDTH-1:0] nxt_b;
  logic             nxt_wrap;

  // Gray-to-binary is a prefix XOR from the MSB down.
  always_comb begin
    ld_bin            = '0;
    ld_bin[WIDTH-1]   = ld_val[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      ld_bin[i] = ld_bin[i+1] ^ ld_val[i];
    end
  end

  always_comb begin
    nxt_b    = bin_out;
    nxt_wrap = 1'b0;
    if (load) begin
      nxt_b = load_gray ? ld_bin : ld_val;
    end else if (en) begin
      if (up) begin
        nxt_b    = bin_out + ONE;
        nxt_wrap = &bin_out;
      end else begin
        nxt_b    = bin_out - ONE;
        nxt_wrap = ~|bin_out;
      end
    end
  end

  // Gray code is taken from the next binary value so both outputs flip on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_out  <= RESET_VAL;
      gray_out <= RESET_GRAY;
      wrap     <= 1'b0;
    end else begin
      bin_out  <= nxt_b;
      gray_out <= nxt_b ^ (nxt_b >> 1);
      wrap     <= nxt_wrap;
    end
  end

endmodule

// File: tb/tb_gray_counter.sv
// Directed-vector bench for gray_counter at WIDTH=4, RESET_VAL=0.
module tb_gray_counter;

  logic       clk = 1'b0;
  logic       clk_run = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic       load_gray = 1'b0;
  logic [3:0] ld_val = 4'd0;
  logic [3:0] bin_out;
  logic [3:0] gray_out;
  logic       wrap;

  int n_vec = 0;
  int n_err = 0;

  gray_counter #(.WIDTH(4), .RESET_VAL(4'd0)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .up        (up),
    .load      (load),
    .load_gray (load_gray),
    .ld_val    (ld_val),
    .bin_out   (bin_out),
    .gray_out  (gray_out),
    .wrap      (wrap)
  );

  always #5 if (clk_run) clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] b, input logic [3:0] g, input logic w);
    chk({tag, ".bin"}, 32'(bin_out), 32'(b));
    chk({tag, ".gray"}, 32'(gray_out), 32'(g));
    chk({tag, ".wrap"}, 32'(wrap), 32'(w));
  endtask

  logic [3:0] gray_seq [17] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                                4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};

  initial begin
    logic [3:0] prev;
    // 1: asynchronous reset with the clock stopped
    #3 rst = 1'b1;
    #1 chk_out("async_rst", 4'h0, 4'h0, 1'b0);
    #5 rst = 1'b0;
    clk_run = 1'b1;
    step();
    chk_out("idle_after_rst", 4'h0, 4'h0, 1'b0);

    // 2: full up count through the wrap
    en = 1'b1; up = 1'b1;
    prev = gray_out;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("up%0d.bin", k), 32'(bin_out), 32'(k % 16));
      chk($sformatf("up%0d.gray", k), 32'(gray_out), 32'(gray_seq[k]));
      chk($sformatf("up%0d.onebit", k), 32'($countones(gray_out ^ prev)), 32'd1);
      chk($sformatf("up%0d.wrap", k), 32'(wrap), 32'(k == 16));
      prev = gray_out;
    end

    // 3: binary and Gray loads
    en = 1'b0; load = 1'b1; load_gray = 1'b0; ld_val = 4'b0011;
    step(); chk_out("ld_bin_0011", 4'b0011, 4'b0010, 1'b0);
    load_gray = 1'b1; ld_val = 4'b1011;
    step(); chk_out("ld_gray_1011", 4'b1101, 4'b1011, 1'b0);
    load_gray = 1'b0; ld_val = 4'b1111;
    step(); chk_out("ld_bin_1111", 4'b1111, 4'b1000, 1'b0);

    // load beats en even at the up-wrap boundary
    en = 1'b1; up = 1'b1;
    step(); chk_out("ld_en_at_ones", 4'b1111, 4'b1000, 1'b0);

    // 4: underflow from zero
    en = 1'b0; ld_val = 4'b0000;
    step(); chk_out("ld_zero", 4'h0, 4'h0, 1'b0);
    load = 1'b0; en = 1'b1; up = 1'b0;
    step(); chk_out("down_wrap", 4'b1111, 4'b1000, 1'b1);
    step(); chk_out("down_after", 4'b1110, 4'b1001, 1'b0);

    // alternating direction at the boundary wraps on consecutive edges
    en = 1'b0; load = 1'b1; ld_val = 4'b0000;
    step();
    load = 1'b0; en = 1'b1; up = 1'b0;
    step(); chk_out("alt_down", 4'b1111, 4'b1000, 1'b1);
    up = 1'b1;
    step(); chk_out("alt_up", 4'b0000, 4'b0000, 1'b1);
    up = 1'b0;
    step(); chk_out("alt_down2", 4'b1111, 4'b1000, 1'b1);

    // 5: priority and hold
    en = 1'b0; load = 1'b1; load_gray = 1'b0; ld_val = 4'b0101;
    step(); chk_out("ld_0101", 4'b0101, 4'b0111, 1'b0);
    en = 1'b1; up = 1'b1; ld_val = 4'b0000;
    step(); chk_out("ld_over_en", 4'b0000, 4'b0000, 1'b0);
    load = 1'b0; en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(); chk_out($sformatf("hold%0d", k), 4'b0000, 4'b0000, 1'b0);
    end

    // 6: mid-count reset
    en = 1'b1; up = 1'b1;
    for (int k = 0; k < 6; k++) step();
    chk_out("pre_rst", 4'b0110, 4'b0101, 1'b0);
    #2 rst = 1'b1;
    #1 chk_out("mid_rst", 4'h0, 4'h0, 1'b0);
    load = 1'b1; ld_val = 4'b1010;
    step(); chk_out("rst_held", 4'h0, 4'h0, 1'b0);
    rst = 1'b0; load = 1'b0;
    step(); chk_out("post_rst", 4'b0001, 4'b0001, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
